// File: rtl/token_source_pkg.sv
`default_nettype none
// ============================================================================
// token_source_pkg : shared types for the Valid/Nack token transmitter
// Revision: 1.0
// ============================================================================
package token_source_pkg;

  typedef enum logic [1:0] {
    sIDLE = 2'd0,
    sSEND = 2'd1,
    sHOLD = 2'd2
  } fsm_tsrc;

  localparam logic [7:0] STALL_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/token_source_if.sv
`default_nettype none
// ============================================================================
// token_source_if : producer handshake, Valid/Nack link and status signals
// Revision: 1.0
// ============================================================================
interface token_source_if #(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 4
) ();

  logic                       I_Req;
  logic [WIDTH_DATA-1:0]      I_Data;
  logic                       O_Ack;
  logic                       I_Flush;
  logic                       O_Valid;
  logic [WIDTH_DATA-1:0]      O_Data;
  logic                       I_Nack;
  logic [$clog2(DEPTH):0]     O_Count;
  logic [7:0]                 O_StallCnt;

  modport slave (
    input  I_Req, I_Data, I_Flush, I_Nack,
    output O_Ack, O_Valid, O_Data, O_Count, O_StallCnt
  );

  modport master (
    output I_Req, I_Data, I_Flush, I_Nack,
    input  O_Ack, O_Valid, O_Data, O_Count, O_StallCnt
  );

endinterface
`default_nettype wire

// File: rtl/token_source_fifo.sv
`default_nettype none
// ============================================================================
// token_fifo : DEPTH-entry FIFO with flush and occupancy counter
// Revision: 1.0
// ============================================================================
module token_fifo
  import token_source_pkg::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [WIDTH_DATA-1:0]     data_i,
  output logic [WIDTH_DATA-1:0]     data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately so full/empty never alias.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/token_source.sv
`default_nettype none
// ============================================================================
// token_source : buffers producer words and issues them as Valid tokens under Nack
// Revision: 1.0
// ============================================================================
module token_source
  import token_source_pkg::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 4
) (
  input  logic           clock,
  input  logic           reset,
  token_source_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fsm_tsrc               state_q, state_d;
  logic [WIDTH_DATA-1:0] data_q, data_d;
  logic                  skid_spent_q, skid_spent_d;
  logic [7:0]            stall_q, stall_d;

  logic                  load;
  logic                  push;
  logic                  valid;
  logic [WIDTH_DATA-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign push  = bus.I_Req & ~fifo_full & ~bus.I_Flush;
  assign valid = (state_q == sSEND);

  token_fifo #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (load),
    .flush_i (bus.I_Flush),
    .data_i  (bus.I_Data),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= sIDLE;
      data_q       <= '0;
      skid_spent_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      skid_spent_q <= skid_spent_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (bus.I_Flush) begin
      state_d = sIDLE;
    end else begin
      case (state_q)
        sIDLE: begin
          // Under Nack only the single skid token of the episode may be launched.
          if (!fifo_empty && (!bus.I_Nack || !skid_spent_q)) begin
            load    = 1'b1;
            state_d = sSEND;
          end
        end
        sSEND: begin
          if (bus.I_Nack) begin
            state_d = sHOLD;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = sIDLE;
          end
        end
        sHOLD: begin
          if (!bus.I_Nack) begin
            if (!fifo_empty) begin
              load    = 1'b1;
              state_d = sSEND;
            end else begin
              state_d = sIDLE;
            end
          end
        end
        default: state_d = sIDLE;
      endcase
    end
  end

  always_comb begin
    data_d       = load ? fifo_head : data_q;
    skid_spent_d = skid_spent_q;
    if (!bus.I_Nack) begin
      skid_spent_d = 1'b0;
    end else if (valid) begin
      skid_spent_d = 1'b1;
    end
    stall_d = stall_q;
    if (bus.I_Nack && (!fifo_empty || valid) && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  assign bus.O_Valid    = valid;
  assign bus.O_Data     = data_q;
  assign bus.O_Ack      = ~fifo_full;
  assign bus.O_Count    = fifo_count;
  assign bus.O_StallCnt = stall_q;

endmodule
`default_nettype wire

// File: doc/token_source.md
# token_source

Transmitter end of the Valid/Nack retiming link. Accepts words from a local producer over a req/ack handshake, buffers them in a small FIFO, and issues them as Valid tokens toward a chain of retiming token units, obeying the Nack backpressure those units return. Sits at the boundary between a data source (load unit, stream port) and the first retiming stage of a compute-cell link.

## Interface
- WIDTH_DATA, 32, token payload width
- DEPTH, 4, FIFO entries; power of two, ≥2

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Req  in  1  local producer offers I_Data
- I_Data  in  WIDTH_DATA  local word
- O_Ack  out  1  FIFO can accept this cycle (= not full)
- I_Flush  in  1  discard all FIFO contents
- O_Valid  out  1  Valid token to first retiming stage, registered
- O_Data  out  WIDTH_DATA  token payload, registered
- I_Nack  in  1  Nack token from first retiming stage, already registered by receiver
- O_Count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding output register
- O_StallCnt  out  8  saturating count of Nack-stalled cycles

## Operation
- Push: I_Req & O_Ack writes I_Data to FIFO tail. O_Ack = (O_Count != DEPTH), from registered state only.
- Link rule: receiver absorbs at most one token issued while I_Nack=1 per Nack episode (episode = maximal run of I_Nack=1 cycles). Any further token in the same episode is lost; the source must never issue one.
- Issue = O_Valid=1 in a cycle. Every issued token counts as delivered; no replay.
- FSM (package typedef fsm_tsrc):
  - sIDLE: O_Valid=0. FIFO nonempty & (~I_Nack | skid unused) → load head into output register, → sSEND. Else stay.
  - sSEND: O_Valid=1. If I_Nack=1 → skid now spent, O_Valid cleared at edge, → sHOLD. Else if FIFO nonempty → load next head, stay. Else → sIDLE.
  - sHOLD: O_Valid=0. I_Nack=0 → sIDLE (and in same edge load head if nonempty → sSEND). I_Nack=1 → stay.
- Skid-unused: in sIDLE with I_Nack=1, the loaded token is presented next cycle; if Nack is still high it consumes the skid.
- Pop occurs only on load into output register; simultaneous push and pop when FIFO is full is not possible (O_Ack=0); when FIFO is empty, push and load in the same cycle do not bypass.
- O_StallCnt increments when I_Nack=1 & (FIFO nonempty | O_Valid=1); saturates at 8'hFF; cleared only by reset.
- I_Flush: empties FIFO and forces sIDLE with O_Valid=0 next cycle; a push in the same cycle is dropped; O_StallCnt is unaffected. Flush wins over every other event.

## Timing
- Reset values: O_Valid=0, O_Data=0, O_Count=0, O_Ack=1, O_StallCnt=0, FSM=sIDLE, pointers 0.
- Reset mid-operation: all FIFO contents and the output token are discarded; no token is issued in the cycle after reset.
- Latency: push at cycle t → O_Valid=1 at t+2 when there is no backpressure.
- Throughput: 1 token/cycle sustained while I_Nack=0.
- Nack release: I_Nack falls at cycle t, FIFO nonempty → next token at t+1.
- Pointers: $clog2(DEPTH) bits, natural wrap; occupancy via separate counter.

## Structure
- pkg_en gains fsm_tsrc {sIDLE, sSEND, sHOLD}.
- One sub-module: token_fifo (DEPTH×WIDTH_DATA, push/pop/flush, count, full/empty). The FSM, output register and stall counter live in token_source.

## Test plan
- Free flow: push 0xA0..0xA3 on consecutive cycles, I_Nack=0 → O_Valid high for 4 consecutive cycles starting 2 cycles after first push, data A0,A1,A2,A3.
- Nack mid-stream: 8 words queued, I_Nack high 3 cycles during sSEND → exactly one token with I_Nack=1, O_Valid=0 for remaining Nack cycles, resume one cycle after Nack falls, no word lost or duplicated, O_StallCnt=3.
- Skid from idle: FIFO empty, I_Nack=1, push 0x55 → one token 0x55 issued under Nack, second push 0x66 held until Nack falls.
- Full: DEPTH=4, I_Nack held high, push 6 words → O_Ack=0 once O_Count=4, extra pushes rejected; after release, all accepted words emerge in order.
- Flush/reset mid-stream: FIFO=3 with Valid high, assert I_Flush (then separately reset) → O_Valid=0, O_Count=0, O_Ack=1 next cycle; reset also clears O_StallCnt.
- Saturation: I_Nack=1 with pending data for 300 cycles → O_StallCnt stops at 0xFF.
